switch_input: RTL and testbench
===============================

SWITCH_INPUT -- requirements
Module: switch_input

Interface
REQ-001 SHALL have parameter DB_COUNT, default 16'd20000, the number of consecutive stable synchronized samples required to accept a button edge (legal range 2..65535).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port phasecounter  input  5  one-hot CPU phase; bit 3 marks the memory-access phase.
REQ-005 SHALL have port switchin  input  1  CPU is executing a switch-read instruction this phase.
REQ-006 SHALL have port btn_raw  input  1  asynchronous push-button level, active-high.
REQ-007 SHALL have port fromswitch  output  1  sticky "press pending" flag, fed to the memory-access stage.
REQ-008 SHALL have port btn_level  output  1  debounced button level.
REQ-009 SHALL have port press_count  output  8  count of accepted presses, for debug display.

Function
REQ-010 SHALL pass btn_raw through a two-flop synchronizer; the FSM SHALL see only the second-flop output, btn_sync.
REQ-011 SHALL implement four FSM states: RELEASED, CONFIRM_PRESS, PRESSED and CONFIRM_RELEASE.
REQ-012 In RELEASED, btn_sync=1 SHALL move to CONFIRM_PRESS and clear the counter to 0.
REQ-013 In CONFIRM_PRESS, btn_sync=0 SHALL return to RELEASED (glitch rejected).
REQ-014 In CONFIRM_PRESS with btn_sync=1: if counter==DB_COUNT-1, SHALL move to PRESSED; otherwise SHALL increment the counter.
REQ-015 CONFIRM_RELEASE SHALL mirror CONFIRM_PRESS with polarity inverted, and SHALL end in RELEASED.
REQ-016 btn_level SHALL be 1 exactly in PRESSED and CONFIRM_RELEASE.
REQ-017 Latency: a btn_raw rise first sampled at edge N (held stable) SHALL make btn_level=1 after edge N+DB_COUNT+2.
REQ-018 The CONFIRM_PRESS->PRESSED transition SHALL set fromswitch=1 and increment press_count, which wraps from 255 to 0.
REQ-019 fromswitch SHALL clear at a rising edge where switchin=1 and phasecounter[3]=1 (the read consumes the press).
REQ-020 If set and clear coincide at one edge, set SHALL win and fromswitch SHALL stay 1.
REQ-021 Further accepted presses while fromswitch=1 SHALL leave fromswitch at 1 and SHALL still increment press_count.
REQ-022 A read with fromswitch=0 SHALL have no effect.
REQ-023 The counter SHALL saturate at DB_COUNT-1 and never wrap.
REQ-024 The FSM state and counter SHALL NOT be altered by switchin or phasecounter.

Reset
REQ-025 reset=0 SHALL immediately force state=RELEASED, counter=0, both synchronizer flops=0, fromswitch=0, btn_level=0 and press_count=0.
REQ-026 Reset asserted mid-confirmation SHALL discard the partial count; after release, a held button SHALL require the full DB_COUNT+3 edges again.

Structure
REQ-027 The FSM state encoding and the phase-bit index (3) SHALL live in the shared CPU constants package.
REQ-028 The synchronizer SHALL be one sub-module, sync_2ff (1-bit, async active-low reset), reusable for other external inputs.

Verification (DB_COUNT=4)
REQ-029 Scenario: btn_raw rises before edge 1 and is held -> fromswitch=1 and btn_level=1 after edge 7; press_count=1.
REQ-030 Scenario: btn_raw high for 3 edges only -> fromswitch stays 0 and press_count stays 0.
REQ-031 Scenario: pending press, then switchin=1 with phasecounter=5'b01000 for one edge -> fromswitch=0 after that edge; switchin=1 with phasecounter=5'b00100 -> no clear.
REQ-032 Scenario: press confirmation and a read at the same edge -> fromswitch remains 1.
REQ-033 Scenario: 256 accepted press/release cycles -> press_count returns to 0.
REQ-034 Scenario: reset pulsed while in CONFIRM_PRESS at counter=2 -> all outputs 0 immediately; re-press confirms only after a full 7 edges.

Source files
------------

// File: rtl/switch_input_pkg.sv
// Shared CPU constants used by the switch input block.
// Holds the phase-bit position, the debounce FSM encoding and small helpers.
package switch_input_pkg;

  // One-hot CPU phase vector width and the bit that marks memory access.
  localparam int PHASE_W       = 5;
  localparam int PHASE_MEM_BIT = 3;

  // Widths of the debounce counter and the accepted-press counter.
  localparam int DB_CNT_W    = 16;
  localparam int PRESS_CNT_W = 8;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    BTN_RELEASED        = 2'd0,
    BTN_CONFIRM_PRESS   = 2'd1,
    BTN_PRESSED         = 2'd2,
    BTN_CONFIRM_RELEASE = 2'd3
  } btn_state_e;

  // A switch read consumes a pending press only in the memory-access phase.
  function automatic logic is_switch_read(input logic [PHASE_W-1:0] phase,
                                          input logic               sw_read);
    return sw_read & phase[PHASE_MEM_BIT];
  endfunction

  // The debounced level is high once a press is accepted and stays high
  // until the release has been confirmed.
  function automatic logic level_of(input btn_state_e s);
    return (s == BTN_PRESSED) || (s == BTN_CONFIRM_RELEASE);
  endfunction

endpackage

// File: rtl/switch_input_sync_2ff.sv
// Two-flop synchronizer for one asynchronous external input.
// Both flops clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to resolve metastability.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_input.sv
// Push-button input for the CPU: synchronize, debounce, count accepted
// presses and hold a sticky "press pending" flag until a switch read.
//
// Press/read protocol: an accepted press raises fromswitch and it stays
// raised (further presses keep it high) until the CPU performs a switch read,
// i.e. a rising clock edge with switchin=1 and the memory-access phase bit
// set. That edge consumes the press and clears the flag, unless a new press is
// accepted at the very same edge, in which case the new press wins and the
// flag stays high. A read with no pending press does nothing.
module switch_input
  import switch_input_pkg::*;
#(
  parameter logic [DB_CNT_W-1:0] DB_COUNT = 16'd20000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PHASE_W-1:0]     phasecounter,
  input  logic                   switchin,
  input  logic                   btn_raw,
  output logic                   fromswitch,
  output logic                   btn_level,
  output logic [PRESS_CNT_W-1:0] press_count,
  output btn_state_e             state_dbg
);

  // Last counter value of a confirmation window; the counter never passes it.
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_COUNT - 16'd1;

  logic                   btn_sync;
  btn_state_e             state_q, state_d;
  logic [DB_CNT_W-1:0]    cnt_q, cnt_d;
  logic                   accept;
  logic                   rd_consume;
  logic                   fromswitch_q, fromswitch_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

  // Only the memory-access bit of the phase matters here.
  logic unused_phase;
  assign unused_phase = ^{phasecounter[PHASE_W-1:PHASE_MEM_BIT+1],
                          phasecounter[PHASE_MEM_BIT-1:0]};

  sync_2ff u_btn_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign rd_consume = is_switch_read(phasecounter, switchin);

  // Register the debounce FSM, its counter and the press bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= BTN_RELEASED;
      cnt_q         <= '0;
      fromswitch_q  <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fromswitch_q  <= fromswitch_d;
      press_count_q <= press_count_d;
    end
  end

  // Debounce next-state: a level change is accepted only after the
  // synchronized input has held the new level for DB_COUNT+1 samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      BTN_RELEASED: begin
        if (btn_sync) begin
          state_d = BTN_CONFIRM_PRESS;
          cnt_d   = '0;
        end
      end
      BTN_CONFIRM_PRESS: begin
        if (!btn_sync) begin
          state_d = BTN_RELEASED;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = BTN_PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BTN_PRESSED: begin
        if (!btn_sync) begin
          state_d = BTN_CONFIRM_RELEASE;
          cnt_d   = '0;
        end
      end
      BTN_CONFIRM_RELEASE: begin
        if (btn_sync) begin
          state_d = BTN_PRESSED;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = BTN_RELEASED;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = BTN_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky pending flag (set beats clear) and the wrapping press counter.
  always_comb begin
    fromswitch_d  = fromswitch_q;
    press_count_d = press_count_q;
    if (accept) begin
      fromswitch_d  = 1'b1;
      press_count_d = press_count_q + 8'd1;
    end else if (rd_consume) begin
      fromswitch_d  = 1'b0;
    end
  end

  assign fromswitch  = fromswitch_q;
  assign btn_level   = level_of(state_q);
  assign press_count = press_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_switch_input.sv
// Bench for switch_input with DB_COUNT=4: directed scenarios with literal
// expectations plus randomized button/read traffic against a run-length model.
module tb_switch_input;
  import switch_input_pkg::*;

  localparam logic [15:0] DB = 16'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] phasecounter = 5'd0;
  logic       switchin = 1'b0;
  logic       btn_raw = 1'b0;
  logic       fromswitch;
  logic       btn_level;
  logic [7:0] press_count;
  btn_state_e state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Clock and DUT.
  always #5 clock = ~clock;

  switch_input #(.DB_COUNT(DB)) dut (
    .clock        (clock),
    .reset        (reset),
    .phasecounter (phasecounter),
    .switchin     (switchin),
    .btn_raw      (btn_raw),
    .fromswitch   (fromswitch),
    .btn_level    (btn_level),
    .press_count  (press_count),
    .state_dbg    (state_dbg)
  );

  // Reference model: raw samples travel through a two-entry queue; the
  // debounced level flips once DB+1 consecutive samples disagree with it.
  logic [0:0] exp_q[$] = '{1'b0, 1'b0};
  logic [0:0] m_y;
  logic       m_level = 1'b0;
  int         m_run = 0;
  logic       m_fs = 1'b0;
  logic [7:0] m_pc = 8'd0;
  logic       m_accept;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q   = '{1'b0, 1'b0};
      m_level = 1'b0;
      m_run   = 0;
      m_fs    = 1'b0;
      m_pc    = 8'd0;
    end else begin
      m_y = exp_q.pop_front();
      exp_q.push_back(btn_raw);
      m_accept = 1'b0;
      if (m_y[0] != m_level) begin
        m_run = m_run + 1;
        if (m_run == int'(DB) + 1) begin
          m_level  = ~m_level;
          m_run    = 0;
          m_accept = m_level;
        end
      end else begin
        m_run = 0;
      end
      if (m_accept) begin
        m_fs = 1'b1;
        m_pc = m_pc + 8'd1;
      end else if (switchin && phasecounter[3]) begin
        m_fs = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_level", {31'd0, btn_level}, {31'd0, m_level});
      check("cyc_fromswitch", {31'd0, fromswitch}, {31'd0, m_fs});
      check("cyc_press_count", {24'd0, press_count}, {24'd0, m_pc});
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic release_btn();
    @(negedge clock);
    switchin     = 1'b0;
    phasecounter = 5'd0;
    btn_raw      = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    do_reset();
    check("reset_level", {31'd0, btn_level}, 32'd0);
    check("reset_fromswitch", {31'd0, fromswitch}, 32'd0);
    check("reset_press_count", {24'd0, press_count}, 32'd0);
    chk_en = 1'b1;

    // Held press: level and flag rise after edge 7, not edge 6.
    btn_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock);
      #1;
      if (e == 6) check("A_level_e6", {31'd0, btn_level}, 32'd0);
    end
    check("A_level_e7", {31'd0, btn_level}, 32'd1);
    check("A_fromswitch_e7", {31'd0, fromswitch}, 32'd1);
    check("A_press_count", {24'd0, press_count}, 32'd1);

    // Reads: wrong phase keeps the flag, memory phase consumes it,
    // a read with nothing pending leaves it clear.
    @(negedge clock);
    switchin = 1'b1; phasecounter = 5'b00100;
    @(posedge clock); #1;
    check("C_nonmem_read", {31'd0, fromswitch}, 32'd1);
    @(negedge clock);
    phasecounter = 5'b01000;
    @(posedge clock); #1;
    check("C_mem_read", {31'd0, fromswitch}, 32'd0);
    @(posedge clock); #1;
    check("C_idle_read", {31'd0, fromswitch}, 32'd0);
    release_btn();
    check("C_released_level", {31'd0, btn_level}, 32'd0);

    // Three-edge glitch is rejected.
    do_reset();
    btn_raw = 1'b1;
    repeat (3) @(negedge clock);
    btn_raw = 1'b0;
    repeat (10) @(negedge clock);
    check("B_glitch_fromswitch", {31'd0, fromswitch}, 32'd0);
    check("B_glitch_press_count", {24'd0, press_count}, 32'd0);
    check("B_glitch_level", {31'd0, btn_level}, 32'd0);

    // Confirmation and memory read at the same edge: set wins.
    btn_raw = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    switchin = 1'b1; phasecounter = 5'b01000;
    @(posedge clock); #1;
    check("D_set_wins", {31'd0, fromswitch}, 32'd1);
    check("D_press_count", {24'd0, press_count}, 32'd1);
    release_btn();

    // Reset in CONFIRM_PRESS with counter=2, then a full re-confirmation.
    btn_raw = 1'b1;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("F_reset_level", {31'd0, btn_level}, 32'd0);
    check("F_reset_fromswitch", {31'd0, fromswitch}, 32'd0);
    check("F_reset_press_count", {24'd0, press_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock);
      #1;
      if (e == 6) check("F_level_e6", {31'd0, btn_level}, 32'd0);
    end
    check("F_level_e7", {31'd0, btn_level}, 32'd1);
    check("F_press_count", {24'd0, press_count}, 32'd1);
    release_btn();

    // 256 clean press/release cycles wrap the press counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      btn_raw = 1'b1;
      repeat (9) @(negedge clock);
      btn_raw = 1'b0;
      repeat (9) @(negedge clock);
      if (i == 254) check("E_count_255", {24'd0, press_count}, 32'd255);
    end
    check("E_count_wrap", {24'd0, press_count}, 32'd0);
    check("E_fromswitch", {31'd0, fromswitch}, 32'd1);

    // Randomized button levels, reads, phases and rare reset pulses.
    for (int s = 0; s < 1500; s++) begin
      int hold;
      btn_raw = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        @(negedge clock);
        switchin     = ($urandom_range(0, 5) == 0);
        phasecounter = 5'(1 << $urandom_range(0, 4));
        if ($urandom_range(0, 299) == 0) begin
          #2 reset = 1'b0;
          #2 reset = 1'b1;
        end
      end
    end

    release_btn();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
